// File: rtl/conv_lut_sched.sv
// conv_lut_sched: sequencer for one shared 4-input/2-output conv LUT slice.
// Slides a 4-bit window across a latched activation row at a fixed stride,
// feeds each window to an external LUT, and accumulates the saturated 2-bit
// results into one sum per row, returned over a valid/ready handshake.
// Optional build macro CONV_LUT_SCHED_PIPE_EN inserts a register stage on the
// LUT result; the accumulator then lags by one cycle and RUN gains a drain cycle.
module conv_lut_sched #(
    parameter int DATA_W = 16,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              lut_bit_1,
    output logic              lut_bit_2,
    output logic              lut_bit_3,
    output logic              lut_bit_4,
    input  logic              lut_dout_bit1,
    input  logic              lut_dout_bit2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              busy
);

    localparam int NPOS  = (DATA_W - 4) / STRIDE + 1;
    localparam int POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] row;
    logic [POS_W-1:0]  pos;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W:0]    acc_wide;
    logic [1:0]        v;
    logic [1:0]        add_v;
    logic [3:0]        win;
    logic              accept;
    logic              last_pos;
    logic              step_done;

    assign v        = {lut_dout_bit2, lut_dout_bit1};
    assign accept   = in_valid && (state == IDLE);
    assign last_pos = (pos == POS_LAST);

`ifdef CONV_LUT_SCHED_PIPE_EN
    logic [1:0] v_q;
    logic       v_vld;
    logic       drain;

    // Pipe stage: capture each window's LUT result; the drain cycle adds the last one.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            v_q   <= '0;
            v_vld <= 1'b0;
            drain <= 1'b0;
        end else if (state == RUN) begin
            v_q   <= v;
            v_vld <= !drain;
            if (last_pos) drain <= 1'b1;
        end
    end

    assign add_v     = v_vld ? v_q : 2'b00;
    assign step_done = (state == RUN) && drain;
`else
    assign add_v     = (state == RUN) ? v : 2'b00;
    assign step_done = (state == RUN) && last_pos;
`endif

    // Saturating add: a carry out of the accumulator clamps to all ones.
    assign acc_wide = {1'b0, acc} + {{(ACC_W - 1){1'b0}}, add_v};
    assign acc_sum  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (step_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: row latch, window position, accumulator and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            row     <= '0;
            pos     <= '0;
            acc     <= '0;
            out_sum <= '0;
        end else if (accept) begin
            row <= in_data;
            pos <= '0;
            acc <= '0;
        end else if (state == RUN) begin
            acc <= acc_sum;
            if (!last_pos)  pos     <= pos + 1'b1;
            if (step_done)  out_sum <= acc_sum;
        end
    end

    // Outputs decoded from state and registers only.
    always_comb begin
        win       = 4'(row >> (pos * STRIDE));
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        lut_bit_1 = (state == RUN) && win[0];
        lut_bit_2 = (state == RUN) && win[1];
        lut_bit_3 = (state == RUN) && win[2];
        lut_bit_4 = (state == RUN) && win[3];
    end

endmodule

// File: doc/conv_lut_sched.md
Name: conv_lut_sched

Overview:
Sequencer for one shared 4-input/2-output conv LUT slice. It accepts a binary activation row, slides a 4-bit window across it at a fixed stride, and drives the window onto an externally instantiated LUT. It samples the 2-bit LUT result each step, accumulates it, and returns one saturated sum per row over a valid/ready handshake. It sits between the row buffer and the kernel output stage.

Parameters:
DATA_W, 16, row width in bits; must be >= 4.
STRIDE, 1, window step in bits; (DATA_W-4) % STRIDE must be 0.
ACC_W, 8, accumulator and result width in bits.
Derived (localparam): NPOS = (DATA_W-4)/STRIDE + 1, the number of window positions.

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  row available
in_ready  out  1  controller can accept a row
in_data  in  DATA_W  activation row
lut_bit_1  out  1  window bit 0 (LSB) to the LUT
lut_bit_2  out  1  window bit 1
lut_bit_3  out  1  window bit 2
lut_bit_4  out  1  window bit 3 (MSB)
lut_dout_bit1  in  1  LUT result low bit (combinational from lut_bit_*)
lut_dout_bit2  in  1  LUT result high bit
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_sum  out  ACC_W  accumulated row result
busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, pos=0, acc=0, row register=0, out_valid=0, out_sum=0, busy=0, lut_bit_1..4=0. in_ready=1 in the cycle after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data, pos<=0, acc<=0, go to RUN.
- RUN:
  - in_ready=0.
  - lut_bit_k = row[pos*STRIDE + k-1], driven from registers only (row, pos).
  - Each cycle, v={lut_dout_bit2,lut_dout_bit1} is sampled and acc <= sat(acc+v).
  - sat clamps at 2^ACC_W-1; acc never wraps.
  - If pos==NPOS-1, go to DONE (that cycle's v is included); otherwise pos<=pos+1.
- DONE:
  - out_valid=1, out_sum=acc; both held stable until out_ready.
  - On out_valid&out_ready, go to IDLE. out_valid drops the next cycle; out_sum keeps its last value.
  - in_ready=0 in DONE: no overlap of accept and result.
- lut_bit_1..4 are 0 whenever state != RUN.
- Latency: accept edge to out_valid = NPOS+1 cycles. Throughput is one row per NPOS+2 cycles minimum, with out_ready tied high.
- in_data is ignored outside the IDLE handshake. in_valid may stay high across rows.
- rst asserted in any state aborts the row: the next cycle is the reset state, with no partial result emitted.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: CONV_LUT_SCHED_PIPE_EN.
- When defined:
  - A register stage captures v (and a valid flag) each RUN cycle. The accumulator adds the registered value one cycle later.
  - After the last position, the FSM spends one extra drain cycle in RUN before DONE.
  - Latency becomes NPOS+2. lut_bit_* timing is unchanged.
  - The pipe register clears on rst.
- When undefined: direct sampling as described above, latency NPOS+1.

Test Plan:
- Bench LUT model: v=2'b01 when {lut_bit_4..lut_bit_1} is 4'b1101, 4'b1110 or 4'b1111, else 2'b00.
- Case 1. Defaults, in_data=16'hFFFF, out_ready=1 -> 13 windows, out_sum=13. out_valid rises exactly 14 cycles after accept (15 with PIPE_EN).
- Case 2. Defaults, in_data=16'h0000 -> out_sum=0. in_ready back to 1 the cycle after the output handshake.
- Case 3. DATA_W=16, STRIDE=4, in_data=16'hD0F0 -> windows 0x0, 0xF, 0x0, 0xD give out_sum=2, out_valid 5 cycles after accept.
- Case 4. ACC_W=4, bench LUT forced to 2'b11, in_data=16'hFFFF -> the sum would be 39 but saturates: out_sum=15 with no wrap.
- Case 5. out_ready low for 6 cycles in DONE, in_valid held high with a new row -> out_valid and out_sum are stable and in_ready=0 throughout. The new row is accepted only after the out handshake and IDLE.
- Case 6. rst pulsed while pos=5 in RUN -> next cycle: out_valid=0, busy=0, in_ready=1, lut_bit_*=0. A following row 16'hFFFF yields out_sum=13, with no carry-over from the aborted row.
